// File: rtl/ex_pkg.sv
// Shared types for the execute/memory boundary: branch codes,
// ALU flag bundle and the registered EX/MEM payload.
package ex_pkg;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   typedef struct packed {
      logic zero;
      logic neg;
      logic ovf;
      logic carry;
   } alu_flags_t;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic link;
   } ex_ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] store_data;
      logic [XLEN-1:0] pc_plus4;
      logic [RAW-1:0]  rd;
      ex_ctrl_t        ctrl;
   } ex_mem_t;

   // Signed less-than after A-B: sign corrected by overflow.
   function automatic logic signed_lt(alu_flags_t f);
      return f.neg ^ f.ovf;
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM bundle: execute-side entry with handshake, registered
// memory-side entry and the fetch redirect.
interface ex_mem_stage_if;
   import ex_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   logic            alu_neg;
   logic            alu_ovf;
   logic            alu_carry;
   logic [XLEN-1:0] store_data;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_target;
   logic [RAW-1:0]  rd;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic            is_branch;
   logic            is_jump;
   logic [2:0]      br_funct3;

   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic [XLEN-1:0] out_store_data;
   logic [XLEN-1:0] out_pc_plus4;
   logic [RAW-1:0]  out_rd;
   logic            out_reg_write;
   logic            out_mem_read;
   logic            out_mem_write;
   logic            out_link;

   modport master (
      output in_valid, alu_result, alu_zero, alu_neg,
      output alu_ovf, alu_carry, store_data, pc_plus4,
      output pc_target, rd, reg_write, mem_read,
      output mem_write, is_branch, is_jump, br_funct3,
      output out_ready,
      input  in_ready, redirect, redirect_pc, out_valid,
      input  out_result, out_store_data, out_pc_plus4,
      input  out_rd, out_reg_write, out_mem_read,
      input  out_mem_write, out_link
   );

   modport slave (
      input  in_valid, alu_result, alu_zero, alu_neg,
      input  alu_ovf, alu_carry, store_data, pc_plus4,
      input  pc_target, rd, reg_write, mem_read,
      input  mem_write, is_branch, is_jump, br_funct3,
      input  out_ready,
      output in_ready, redirect, redirect_pc, out_valid,
      output out_result, out_store_data, out_pc_plus4,
      output out_rd, out_reg_write, out_mem_read,
      output out_mem_write, out_link
   );

endinterface

// File: rtl/branch_resolve.sv
// Branch decision from the A-B ALU flags; jumps are always taken.
module branch_resolve
   import ex_pkg::*;
(
   input  alu_flags_t flags,
   input  logic [2:0] funct3,
   input  logic       is_branch,
   input  logic       is_jump,
   output logic       taken
);

   logic cond;

   always_comb begin
      cond = 1'b0;
      unique case (funct3)
         BR_BEQ:  cond = flags.zero;
         BR_BNE:  cond = !flags.zero;
         BR_BLT:  cond = signed_lt(flags);
         BR_BGE:  cond = !signed_lt(flags);
         BR_BLTU: cond = !flags.carry;
         BR_BGEU: cond = flags.carry;
         default: cond = 1'b0;
      endcase
      taken = is_jump || (is_branch && cond);
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: branch redirect plus a two-entry skid buffer
// so a memory stall never reaches execute combinationally.
module ex_mem_stage
   import ex_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int REG_AW = RAW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   ex_mem_stage_if.slave bus
);

   alu_flags_t flags;
   ex_mem_t    in_pl;
   ex_mem_t    main_q;
   ex_mem_t    skid_q;
   logic       main_v;
   logic       skid_v;
   logic       ready;
   logic       accept;
   logic       taken;

   always_comb begin
      flags       = '0;
      flags.zero  = bus.alu_zero;
      flags.neg   = bus.alu_neg;
      flags.ovf   = bus.alu_ovf;
      flags.carry = bus.alu_carry;
   end

   always_comb begin
      in_pl                = '0;
      in_pl.result         = bus.alu_result[DATA_W-1:0];
      in_pl.store_data     = bus.store_data[DATA_W-1:0];
      in_pl.pc_plus4       = bus.pc_plus4[DATA_W-1:0];
      in_pl.rd             = bus.rd[REG_AW-1:0];
      in_pl.ctrl.reg_write = bus.reg_write;
      in_pl.ctrl.mem_read  = bus.mem_read;
      in_pl.ctrl.mem_write = bus.mem_write;
      in_pl.ctrl.link      = bus.is_jump;
   end

   branch_resolve u_br (
      .flags     (flags),
      .funct3    (bus.br_funct3),
      .is_branch (bus.is_branch),
      .is_jump   (bus.is_jump),
      .taken     (taken)
   );

   // Ready depends only on skid state, never on out_ready.
   assign ready  = !skid_v;
   assign accept = bus.in_valid && ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else if (!main_v || bus.out_ready) begin
         if (skid_v) begin
            main_q <= skid_q;
            main_v <= 1'b1;
            skid_v <= accept;
            if (accept) skid_q <= in_pl;
         end else begin
            main_v <= accept;
            if (accept) main_q <= in_pl;
         end
      end else if (accept) begin
         skid_q <= in_pl;
         skid_v <= 1'b1;
      end
   end

   assign bus.in_ready       = ready;
   assign bus.redirect       = accept && taken;
   assign bus.redirect_pc    = bus.pc_target;
   assign bus.out_valid      = main_v;
   assign bus.out_result     = main_q.result;
   assign bus.out_store_data = main_q.store_data;
   assign bus.out_pc_plus4   = main_q.pc_plus4;
   assign bus.out_rd         = main_q.rd;
   assign bus.out_reg_write  = main_q.ctrl.reg_write;
   assign bus.out_mem_read   = main_q.ctrl.mem_read;
   assign bus.out_mem_write  = main_q.ctrl.mem_write;
   assign bus.out_link       = main_q.ctrl.link;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed branch and
// stall/flush/reset scenarios followed by random traffic.
module tb_ex_mem_stage;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   ex_mem_stage_if bus ();

   ex_mem_stage dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [104:0] q[$];
   logic         mon_on = 1'b0;
   logic         exp_acc = 1'b0;
   logic         exp_redir = 1'b0;
   logic [31:0]  exp_tgt = '0;
   logic         last_acc = 1'b0;

   logic [31:0] s_a, s_b, s_sd, s_pc4, s_tgt;
   logic [4:0]  s_rd;
   logic [2:0]  s_f3;
   logic        s_rw, s_mr, s_mw, s_isb, s_isj;

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h",
                  nm, act, req);
      end
   endtask

   function automatic logic [104:0] act_payload();
      return {bus.out_result, bus.out_store_data,
              bus.out_pc_plus4, bus.out_rd,
              bus.out_reg_write, bus.out_mem_read,
              bus.out_mem_write, bus.out_link};
   endfunction

   // Branch outcome from the operands themselves.
   function automatic logic ref_taken(
      input logic [31:0] a, input logic [31:0] b,
      input logic [2:0] f3, input logic isb,
      input logic isj);
      logic c;
      case (f3)
         3'd0:    c = (a == b);
         3'd1:    c = (a != b);
         3'd4:    c = ($signed(a) < $signed(b));
         3'd5:    c = ($signed(a) >= $signed(b));
         3'd6:    c = (a < b);
         3'd7:    c = (a >= b);
         default: c = 1'b0;
      endcase
      return isj || (isb && c);
   endfunction

   task automatic step(input logic v, input logic o,
                       input logic f, input logic r);
      logic [31:0] res;
      @(posedge clk);
      #1;
      res = s_a - s_b;
      rst = r;
      flush = f;
      bus.in_valid   = v;
      bus.out_ready  = o;
      bus.alu_result = res;
      bus.alu_zero   = (res == 32'd0);
      bus.alu_neg    = res[31];
      bus.alu_ovf    = (s_a[31] != s_b[31]) &&
                       (res[31] != s_a[31]);
      bus.alu_carry  = (s_a >= s_b);
      bus.store_data = s_sd;
      bus.pc_plus4   = s_pc4;
      bus.pc_target  = s_tgt;
      bus.rd         = s_rd;
      bus.reg_write  = s_rw;
      bus.mem_read   = s_mr;
      bus.mem_write  = s_mw;
      bus.is_branch  = s_isb;
      bus.is_jump    = s_isj;
      bus.br_funct3  = s_f3;
      exp_acc   = v && !f && (q.size() < 2);
      exp_redir = exp_acc &&
                  ref_taken(s_a, s_b, s_f3, s_isb, s_isj);
      exp_tgt   = s_tgt;
      @(negedge clk);
      #2;
      last_acc = exp_acc && !r;
      if (r || f) q.delete();
      else if (exp_acc)
         q.push_back({res, s_sd, s_pc4, s_rd,
                      s_rw, s_mr, s_mw, s_isj});
   endtask

   task automatic send(input logic o);
      int n;
      n = 0;
      do begin
         step(1'b1, o, 1'b0, 1'b0);
         n++;
      end while (!last_acc && n < 20);
      chk("send_accept", 128'(last_acc), 128'(1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic set_alu(input logic [31:0] v);
      s_a   = v;
      s_b   = 32'd0;
      s_isb = 1'b0;
      s_isj = 1'b0;
      s_sd  = $urandom;
      s_pc4 = $urandom;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
      chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
      chk({tag, "_out_data"}, 128'(act_payload()), 128'(0));
   endtask

   task automatic set_br(input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] b);
      s_isb = 1'b1;
      s_isj = 1'b0;
      s_f3  = f3;
      s_a   = a;
      s_b   = b;
      s_rw  = 1'b0;
      s_tgt = 32'h0000_0100;
   endtask

   // Monitor: compares every cycle, pops on an output handshake.
   initial begin
      logic [104:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (mon_on) begin
            chk("out_valid", 128'(bus.out_valid),
                128'(q.size() > 0));
            chk("in_ready", 128'(bus.in_ready),
                128'(q.size() < 2));
            chk("redirect", 128'(bus.redirect),
                128'(exp_redir));
            if (exp_redir)
               chk("redirect_pc", 128'(bus.redirect_pc),
                   128'(exp_tgt));
            if (bus.out_valid && bus.out_ready &&
                !rst && !flush) begin
               if (q.size() == 0) begin
                  chk("out_underflow", 128'(1), 128'(0));
               end else begin
                  e = q.pop_front();
                  chk("payload", 128'(act_payload()), 128'(e));
               end
            end
         end
      end
   end

   initial begin
      logic v, o, f, r;
      rst = 1'b1;
      flush = 1'b0;
      s_a = '0; s_b = '0; s_sd = '0; s_pc4 = '0;
      s_tgt = '0; s_rd = '0; s_f3 = '0;
      s_rw = 1'b0; s_mr = 1'b0; s_mw = 1'b0;
      s_isb = 1'b0; s_isj = 1'b0;

      step(1'b0, 1'b1, 1'b0, 1'b1);
      mon_on = 1'b1;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk_reset("reset");

      // First entry: result 0x2A to x5.
      set_alu(32'h0000_002A);
      s_rd = 5'd5;
      s_rw = 1'b1;
      send(1'b1);
      idle(1);

      set_br(3'd0, 32'd7, 32'd7);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      set_br(3'd0, 32'd7, 32'd8);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      set_br(3'd4, 32'hFFFF_FFFF, 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      set_br(3'd6, 32'hFFFF_FFFF, 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      set_br(3'd5, 32'h8000_0000, 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      set_br(3'd2, 32'd3, 32'd3);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);

      // Stream 1..4 with a stall after the first.
      s_rw = 1'b1;
      set_alu(32'd1); send(1'b1);
      set_alu(32'd2); send(1'b0);
      set_alu(32'd3);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b1);
      set_alu(32'd4); send(1'b1);
      idle(3);

      // Fill both slots, then flush a jump.
      set_alu(32'h11); send(1'b0);
      set_alu(32'h22); send(1'b0);
      set_alu(32'h33);
      s_isj = 1'b1;
      s_tgt = 32'h0000_0200;
      step(1'b1, 1'b0, 1'b1, 1'b0);
      s_isj = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
      chk("flush_in_ready", 128'(bus.in_ready), 128'(1));
      idle(2);

      // Reset in the middle of a full stall.
      set_alu(32'h44); send(1'b0);
      set_alu(32'h45); send(1'b0);
      set_alu(32'h46);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk_reset("stall_reset");
      set_alu(32'h55); send(1'b1);
      idle(3);

      for (int i = 0; i < 600; i++) begin
         s_a   = $urandom;
         case ($urandom_range(3, 0))
            0:       s_b = s_a;
            1:       s_b = s_a ^ 32'h8000_0000;
            default: s_b = $urandom;
         endcase
         s_sd  = $urandom;
         s_pc4 = $urandom;
         s_tgt = $urandom;
         s_rd  = 5'($urandom_range(31, 0));
         s_f3  = 3'($urandom_range(7, 0));
         s_rw  = 1'($urandom_range(1, 0));
         s_mr  = 1'($urandom_range(1, 0));
         s_mw  = 1'($urandom_range(1, 0));
         s_isb = 1'($urandom_range(1, 0));
         s_isj = ($urandom_range(7, 0) == 0);
         v = ($urandom_range(3, 0) != 0);
         o = ($urandom_range(9, 0) < 7);
         f = ($urandom_range(19, 0) == 0);
         r = ($urandom_range(99, 0) == 0);
         step(v, o, f, r);
      end

      s_isb = 1'b0;
      s_isj = 1'b0;
      idle(6);
      chk("drain_empty", 128'(q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Downstream neighbour of the ALU in the execute stage.
- Resolves branches from the ALU flags and result, and registers ALU result plus control into the EX/MEM pipeline boundary.
- Uses a 2-entry skid buffer with a valid/ready handshake, so a memory-stage stall never combinationally reaches the decode/execute path.
- Drives redirect (PC select and target) to fetch.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data, PC).
- REG_AW, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  kill all held and incoming entries this cycle
- in_valid  input  1  execute-stage entry present
- in_ready  output  1  stage can accept an entry
- alu_result  input  DATA_W  ALU Result
- alu_zero  input  1  ALU Zero
- alu_neg  input  1  ALU Negative
- alu_ovf  input  1  ALU OverFlow
- alu_carry  input  1  ALU Carry
- store_data  input  DATA_W  rs2 value for stores
- pc_plus4  input  DATA_W  link value
- pc_target  input  DATA_W  precomputed branch/jump target
- rd  input  REG_AW  destination register
- reg_write  input  1  writes rd
- mem_read  input  1  load
- mem_write  input  1  store
- is_branch  input  1  conditional branch
- is_jump  input  1  JAL/JALR
- br_funct3  input  3  branch type
- redirect  output  1  taken branch/jump accepted this cycle
- redirect_pc  output  DATA_W  fetch target
- out_valid  output  1  MEM entry present
- out_ready  input  1  memory stage accepts
- out_result, out_store_data, out_pc_plus4  output  DATA_W  registered copies
- out_rd  output  REG_AW  registered rd
- out_reg_write, out_mem_read, out_mem_write, out_link  output  1  registered control; out_link = is_jump

Behaviour:
- Clocking and reset: one clock domain (clk); rst is synchronous, active-high.
- Reset values: out_valid=0, in_ready=1, all out_* data and control = 0, skid entry invalid.
- Acceptance: an entry is accepted when in_valid && in_ready && !flush.

Branch resolution (combinational, on the input entry; ALU performed A-B):
- 000 BEQ: taken = zero.
- 001 BNE: taken = !zero.
- 100 BLT: taken = neg ^ ovf.
- 101 BGE: taken = !(neg ^ ovf).
- 110 BLTU: taken = !carry.
- 111 BGEU: taken = carry.
- 010 and 011: never taken.
- redirect = accept && (is_jump || (is_branch && taken)).
- redirect_pc = pc_target. Zero-cycle latency.
- Branches still occupy a MEM slot, with reg_write as supplied (normally 0).

Storage:
- main register feeds out_*; skid register holds one overflow entry.
- in_ready = !skid_valid, registered (no combinational out_ready -> in_ready path).

Per-cycle update, evaluated in priority order:
1. rst: clear everything.
2. flush: main and skid valid <= 0; no acceptance.
3. Main empty or out_ready: main <= skid if skid_valid, else the accepted input; skid <= accepted input if skid_valid was set, else invalid.
4. Main full and !out_ready: an accepted input goes to skid (only possible while skid is empty).

Invariants:
- Entries leave in acceptance order; no drop, no duplication.
- Throughput is 1 per cycle while out_ready=1.
- Input-to-out_valid latency is 1 cycle when empty.
- Simultaneous accept and drain with skid empty is a pass-through: main updates and skid stays empty.
- Data registers may hold stale values while their valid bit is 0.

Decomposition:
- Shared package ex_pkg:
  - BR_BEQ..BR_BGEU funct3 constants.
  - Flag bundle typedef (zero, neg, ovf, carry).
  - EX/MEM payload struct (result, store_data, pc_plus4, rd, control bits), so the main and skid registers are one struct each.
- Sub-module branch_resolve: combinational flags + funct3 + is_branch + is_jump -> taken. Verified separately against all 8 funct3 values.

Test Plan:
- Reset, then in_valid=1, alu_result=0x0000_002A, rd=5, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=0x2A, out_rd=5, out_reg_write=1; redirect=0.
- BEQ with alu_zero=1, pc_target=0x0000_0100 -> redirect=1, redirect_pc=0x100 same cycle. Repeat with alu_zero=0 -> redirect=0.
- BLT with A=-1 and B=1 (neg=1, ovf=0) -> taken. BLTU with the same operands (carry=1) -> not taken. BGE with 0x8000_0000 - 1 (neg=0, ovf=1) -> not taken.
- Stream results 1,2,3,4 with out_ready held low from cycle 2:
  - in_ready drops after skid fills.
  - Releasing out_ready yields 1,2,3,4 in order with no gaps or duplicates.
- Main and skid both full, then flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed input is never emitted and redirect=0.
- rst asserted mid-stall with the skid full -> outputs return to reset values on the next edge; the first post-reset entry emerges alone.
